// File: rtl/ga_pkg.sv
// Shared definitions for the GA pipeline stages: fitness width, replacement FSM
// states and the fitness ordering compare.
package ga_pkg;

  localparam int FITNESS_WIDTH = 64;

  typedef enum logic [1:0] {
    S_DONE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SCAN   = 2'd2,
    S_COMMIT = 2'd3
  } repl_state_t;

  // Non-negative doubles without NaN order the same as their raw bit patterns.
  function automatic logic fitness_gt(input logic [FITNESS_WIDTH-1:0] a,
                                      input logic [FITNESS_WIDTH-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/ga_population_rf.sv
// Population register file: one write port, an asynchronous selection read port
// and an asynchronous fitness-only port used by the worst-entry scan.
module ga_population_rf
  import ga_pkg::*;
#(
  parameter int POP_SIZE   = 16,
  parameter int DATA_WIDTH = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(POP_SIZE)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]         wchrom,
  input  logic [FITNESS_WIDTH-1:0]      wfit,
  input  logic [$clog2(POP_SIZE)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_chrom,
  output logic [FITNESS_WIDTH-1:0]      rd_fitness,
  input  logic [$clog2(POP_SIZE)-1:0]   scan_addr,
  output logic [FITNESS_WIDTH-1:0]      scan_fitness
);

  logic [DATA_WIDTH-1:0]    chrom_mem [POP_SIZE];
  logic [FITNESS_WIDTH-1:0] fit_mem   [POP_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < POP_SIZE; i++) begin
        chrom_mem[i] <= '0;
        fit_mem[i]   <= '0;
      end
    end else if (we) begin
      chrom_mem[waddr] <= wchrom;
      fit_mem[waddr]   <= wfit;
    end
  end

  assign rd_chrom     = chrom_mem[rd_addr];
  assign rd_fitness   = fit_mem[rd_addr];
  assign scan_fitness = fit_mem[scan_addr];

endmodule

// File: rtl/replacement_unit.sv
// Steady-state replacement stage: scans the population for its worst member and
// overwrites it with each strictly fitter offspring, tracking the best so far.
//
// state    | meaning
// S_DONE   | generation complete; init writes allowed; waits for progress_pipeline
// S_WAIT   | ready for the next offspring
// S_SCAN   | walking entries 0..POP_SIZE-1 to find the worst (lowest index on ties)
// S_COMMIT | replace worst if offspring is fitter, update best, count offspring
module replacement_unit
  import ga_pkg::*;
#(
  parameter int POP_SIZE        = 16,
  parameter int OFFSPRING_COUNT = 4,
  parameter int DATA_WIDTH      = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          progress_pipeline,
  input  logic                          init_we,
  input  logic [$clog2(POP_SIZE)-1:0]   init_addr,
  input  logic [DATA_WIDTH-1:0]         init_chrom,
  input  logic [FITNESS_WIDTH-1:0]      init_fitness,
  input  logic                          offspring_valid,
  output logic                          offspring_ready,
  input  logic [DATA_WIDTH-1:0]         offspring_chrom,
  input  logic [FITNESS_WIDTH-1:0]      offspring_fitness,
  input  logic [$clog2(POP_SIZE)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_chrom,
  output logic [FITNESS_WIDTH-1:0]      rd_fitness,
  output logic                          replacement_done,
  output logic [DATA_WIDTH-1:0]         best_found_reg,
  output logic [FITNESS_WIDTH-1:0]      best_found_fitness,
  output logic                          protocol_err
);

  localparam int AW = $clog2(POP_SIZE);
  localparam int CW = $clog2(OFFSPRING_COUNT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(POP_SIZE - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OFFSPRING_COUNT - 1);

  repl_state_t              state;
  logic [AW-1:0]            scan_idx;
  logic [AW-1:0]            worst_idx;
  logic [FITNESS_WIDTH-1:0] worst_fit;
  logic [DATA_WIDTH-1:0]    hold_chrom;
  logic [FITNESS_WIDTH-1:0] hold_fit;
  logic [CW-1:0]            count;
  logic [FITNESS_WIDTH-1:0] scan_fitness;

  logic                     init_ok;
  logic                     replace;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [DATA_WIDTH-1:0]    wchrom;
  logic [FITNESS_WIDTH-1:0] wfit;

  assign init_ok = (state == S_DONE) && init_we;
  assign replace = (state == S_COMMIT) && fitness_gt(hold_fit, worst_fit);
  assign we      = init_ok || replace;
  assign waddr   = replace ? worst_idx  : init_addr;
  assign wchrom  = replace ? hold_chrom : init_chrom;
  assign wfit    = replace ? hold_fit   : init_fitness;

  ga_population_rf #(
    .POP_SIZE   (POP_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rf (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wchrom       (wchrom),
    .wfit         (wfit),
    .rd_addr      (rd_addr),
    .rd_chrom     (rd_chrom),
    .rd_fitness   (rd_fitness),
    .scan_addr    (scan_idx),
    .scan_fitness (scan_fitness)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_DONE;
      scan_idx           <= '0;
      worst_idx          <= '0;
      worst_fit          <= '0;
      hold_chrom         <= '0;
      hold_fit           <= '0;
      count              <= '0;
      best_found_reg     <= '0;
      best_found_fitness <= '0;
      protocol_err       <= 1'b0;
    end else begin
      if ((progress_pipeline || init_we) && state != S_DONE)
        protocol_err <= 1'b1;
      case (state)
        S_DONE: begin
          if (init_we && fitness_gt(init_fitness, best_found_fitness)) begin
            best_found_reg     <= init_chrom;
            best_found_fitness <= init_fitness;
          end
          if (progress_pipeline) begin
            count <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (offspring_valid) begin
            hold_chrom <= offspring_chrom;
            hold_fit   <= offspring_fitness;
            scan_idx   <= '0;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Strict less-than keeps the lowest index among equal worst entries.
          if (scan_idx == '0 || fitness_gt(worst_fit, scan_fitness)) begin
            worst_idx <= scan_idx;
            worst_fit <= scan_fitness;
          end
          scan_idx <= scan_idx + AW'(1);
          if (scan_idx == LAST_IDX)
            state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (fitness_gt(hold_fit, best_found_fitness)) begin
            best_found_reg     <= hold_chrom;
            best_found_fitness <= hold_fit;
          end
          count <= count + CW'(1);
          state <= (count == LAST_CNT) ? S_DONE : S_WAIT;
        end
        default: state <= S_DONE;
      endcase
    end
  end

  assign replacement_done = (state == S_DONE);
  assign offspring_ready  = (state == S_WAIT);

endmodule
